condicionador_botoes: RTL and testbench
=======================================

// Module: condicionador_botoes
// PURPOSE
//   Input stage between the raw push-buttons and the game datapath/FSM.
//   Synchronises and debounces the 4 botoes, accepts exactly one press per
//   press/release cycle, and emits a registered jogada with a 1-cycle
//   tem_jogada pulse consumed by the game's jogada register and control FSM.
//   Runs on the 1 kHz system clock, so 1 cycle = 1 ms.
// PARAMETERS
//   DEBOUNCE_CICLOS  20  consecutive stable cycles needed to accept a press or a release (>=2)
//   CW               5   width of debounce counter; must hold DEBOUNCE_CICLOS-1
// PORTS
//   clock        in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high; clears all state
//   habilita     in   1  from game FSM; 0 = presses filtered but no tem_jogada emitted
//   botoes       in   4  raw buttons, active-high, asynchronous to clock
//   jogada       out  4  one-hot code of last accepted press, held until next accept
//   tem_jogada   out  1  1-cycle pulse, coincident with jogada update
//   erro_multiplo out 1  sticky: set when a multi-button press is stably detected
//   db_estado    out  3  FSM state code for hex display
// BEHAVIOUR
//   Reset (async, active-high): jogada=0000, tem_jogada=0, erro_multiplo=0,
//     db_estado=000, counter=0, synchroniser FFs=0, FSM=OCIOSO.
//   Synchroniser: 2 FFs per bit; FSM sees botoes_s only.
//   FSM (codes in db_estado):
//     OCIOSO    000: botoes_s!=0 -> FILTRA, capture amostra=botoes_s, cnt=0.
//     FILTRA    001: botoes_s!=amostra -> OCIOSO (glitch, no output).
//                    else cnt++; at cnt==DEBOUNCE_CICLOS-1 -> ACEITA.
//     ACEITA    010: single cycle. tem_jogada=habilita; if habilita,
//                    jogada<=amostra. -> PRESSIONADO.
//     PRESSIONADO 011: botoes_s==0 -> SOLTA, cnt=0. Other changes ignored.
//     SOLTA     100: botoes_s!=0 -> PRESSIONADO (bounce, no new pulse).
//                    else cnt++; at cnt==DEBOUNCE_CICLOS-1 -> OCIOSO.
//   Latency: press stable from edge k -> tem_jogada high for the cycle after
//     edge k+DEBOUNCE_CICLOS+2; jogada valid same cycle, held after.
//   Exactly one tem_jogada per press/release; holding a button never repeats.
//   Next press accepted only after release is stable DEBOUNCE_CICLOS cycles.
//   habilita sampled only in ACEITA; a press seen with habilita=0 is consumed
//     (no pulse, jogada unchanged) and will not fire later.
//   Multi-button (amostra has >1 bit set) at ACEITA: erro_multiplo<=1
//     (sticky until reset); tem_jogada/jogada per CONFIGURATION.
//   Reset mid-press: FSM returns to OCIOSO; a still-held button is treated
//     as a new press after sync+debounce.
//   Counter saturates logically: never wraps; compare uses CW bits.
// CONFIGURATION
//   Macro REJEITA_MULTIPLO_EN:
//     defined  : multi-button press -> no tem_jogada, jogada unchanged,
//                erro_multiplo set.
//     undefined: multi-button press -> lowest-index set bit wins
//                (1010->0010), tem_jogada pulses, erro_multiplo still set.
// TESTING
//   1 reset=1 2 cycles, botoes=0001 held -> outputs 0 during reset; after
//     release of reset, single tem_jogada 22 edges later, jogada=0001.
//   2 botoes=0100 held 200 cycles -> exactly one tem_jogada, jogada=0100,
//     db_estado=011 while held, 000 DEBOUNCE_CICLOS+2 cycles after release.
//   3 bounce: 0010 toggled every 3 cycles for 15 cycles then stable 30 ->
//     exactly one pulse, jogada=0010; bounce on release -> no second pulse.
//   4 habilita=0, press 1000 -> no pulse, jogada keeps prior value; next
//     press 0001 with habilita=1 -> pulse, jogada=0001.
//   5 botoes=1010 stable 40 cycles -> erro_multiplo=1; with
//     REJEITA_MULTIPLO_EN no pulse; without it pulse, jogada=0010.
//   6 reset asserted in FILTRA and in SOLTA -> immediate return to 000
//     state, tem_jogada=0, no spurious pulse after reset release.

Source files
------------

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: push-button input stage for the game.
// Two-FF synchroniser, debounce FSM, one accepted press per press/release
// cycle, registered jogada with a single-cycle tem_jogada pulse.
// Optional build macro REJEITA_MULTIPLO_EN: when defined, a multi-button press
// produces no pulse and leaves jogada unchanged; when undefined, the
// lowest-index pressed button wins. erro_multiplo is set in both builds.
module condicionador_botoes #(
  parameter int unsigned DEBOUNCE_CICLOS = 20,
  parameter int unsigned CW              = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       erro_multiplo,
  output logic [2:0] db_estado
);

  localparam int unsigned NB      = 4;
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [2:0] {
    OCIOSO      = 3'b000,
    FILTRA      = 3'b001,
    ACEITA      = 3'b010,
    PRESSIONADO = 3'b011,
    SOLTA       = 3'b100
  } estado_t;

  estado_t       estado, estado_d;
  logic [NB-1:0] sync1, botoes_s;
  logic [NB-1:0] amostra, amostra_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [NB-1:0] jogada_d;
  logic          tem_jogada_d;
  logic          erro_d;
  logic          multiplo_c;
  logic [NB-1:0] menor_bit_c;

  // Two-stage synchroniser for the asynchronous buttons
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      botoes_s <= '0;
    end else begin
      sync1    <= botoes;
      botoes_s <= sync1;
    end
  end

  // More than one button in the captured sample, and its lowest set bit
  assign multiplo_c  = (amostra & NB'(amostra - NB'(1))) != '0;
  assign menor_bit_c = amostra & NB'(~amostra + NB'(1));

  // State, counter, sample and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= OCIOSO;
      cnt           <= '0;
      amostra       <= '0;
      jogada        <= '0;
      tem_jogada    <= 1'b0;
      erro_multiplo <= 1'b0;
    end else begin
      estado        <= estado_d;
      cnt           <= cnt_d;
      amostra       <= amostra_d;
      jogada        <= jogada_d;
      tem_jogada    <= tem_jogada_d;
      erro_multiplo <= erro_d;
    end
  end

  // Next-state and next-output logic; outputs are loaded on entry to ACEITA
  // so that they are valid during the ACEITA cycle
  always_comb begin
    estado_d     = estado;
    cnt_d        = cnt;
    amostra_d    = amostra;
    jogada_d     = jogada;
    tem_jogada_d = 1'b0;
    erro_d       = erro_multiplo;
    case (estado)
      OCIOSO: begin
        if (botoes_s != '0) begin
          estado_d  = FILTRA;
          amostra_d = botoes_s;
          cnt_d     = '0;
        end
      end
      FILTRA: begin
        if (botoes_s != amostra) begin
          estado_d = OCIOSO;
        end else if (cnt == CNT_FIM) begin
          estado_d = ACEITA;
          if (multiplo_c) begin
            erro_d = 1'b1;
          end
`ifdef REJEITA_MULTIPLO_EN
          if (habilita && !multiplo_c) begin
            tem_jogada_d = 1'b1;
            jogada_d     = amostra;
          end
`else
          if (habilita) begin
            tem_jogada_d = 1'b1;
            jogada_d     = menor_bit_c;
          end
`endif
        end else begin
          cnt_d = CW'(cnt + CW'(1));
        end
      end
      ACEITA: begin
        estado_d = PRESSIONADO;
      end
      PRESSIONADO: begin
        if (botoes_s == '0) begin
          estado_d = SOLTA;
          cnt_d    = '0;
        end
      end
      SOLTA: begin
        if (botoes_s != '0) begin
          estado_d = PRESSIONADO;
        end else if (cnt == CNT_FIM) begin
          estado_d = OCIOSO;
        end else begin
          cnt_d = CW'(cnt + CW'(1));
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Testbench for condicionador_botoes: directed scenarios plus random button
// activity, checked by a stable-run reference model and a pulse scoreboard.
module tb_condicionador_botoes;

  localparam int DEB = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b1;
  logic [3:0] botoes = 4'b0001;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       erro_multiplo;
  logic [2:0] db_estado;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  logic [3:0] exp_q[$];

  // reference model state
  logic [3:0] p1 = '0, p2 = '0, s;
  int         mode = 0;          // 0 waiting press, 1 accept cycle, 2 waiting release
  logic [3:0] run_val = '0;
  int         run_len = 0;
  int         zero_run = 0;
  logic [3:0] m_jog = '0;
  logic       m_erro = 1'b0;

  condicionador_botoes #(.DEBOUNCE_CICLOS(DEB), .CW(5)) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .botoes(botoes),
    .jogada(jogada),
    .tem_jogada(tem_jogada),
    .erro_multiplo(erro_multiplo),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Press accepted after a stable run: decide the visible effect
  task automatic aceita(input logic [3:0] v, input logic hab);
    logic multi;
    logic [3:0] low;
    multi = $countones(v) > 1;
    low = '0;
    for (int i = 3; i >= 0; i--) if (v[i]) low = 4'(1 << i);
    if (multi) m_erro = 1'b1;
`ifdef REJEITA_MULTIPLO_EN
    if (hab && !multi) begin
      m_jog = v;
      exp_q.push_back(v);
    end
`else
    if (hab) begin
      m_jog = low;
      exp_q.push_back(low);
    end
`endif
  endtask

  // Reference model: the FSM input is the button value two edges old; a
  // press needs DEB+1 consecutive identical nonzero samples, a release
  // DEB+1 consecutive zero samples, with the sample that breaks a press run
  // discarded and the sample on the accept edge+1 ignored.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      p1 = '0; p2 = '0; mode = 0; run_len = 0; zero_run = 0;
      m_jog = '0; m_erro = 1'b0;
      exp_q.delete();
    end else begin
      s = p2; p2 = p1; p1 = botoes;
      case (mode)
        0: begin
          if (run_len == 0) begin
            if (s != 0) begin run_val = s; run_len = 1; end
          end else if (s == run_val) begin
            run_len++;
            if (run_len == DEB + 1) begin
              aceita(run_val, habilita);
              mode = 1;
              run_len = 0;
            end
          end else begin
            run_len = 0;
          end
        end
        1: begin
          mode = 2;
          zero_run = 0;
        end
        default: begin
          if (s == 0) begin
            zero_run++;
            if (zero_run == DEB + 1) mode = 0;
          end else begin
            zero_run = 0;
          end
        end
      endcase
    end
  end

  // Monitor: match each pulse against the scoreboard, check held outputs
  always @(negedge clock) begin
    if (tem_jogada) begin
      pulses++;
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", 1, 0);
      end else begin
        chk("pulse_jogada", int'(jogada), int'(exp_q.pop_front()));
      end
    end
    chk("missing_pulse", exp_q.size(), 0);
    exp_q.delete();
    chk("jogada_held", int'(jogada), int'(m_jog));
    chk("erro_multiplo", int'(erro_multiplo), int'(m_erro));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  int n_lat;
  int p0;

  initial begin
    // 1: reset with a held button, then latency of the first accept
    step(2);
    chk("t1_rst_jogada", int'(jogada), 0);
    chk("t1_rst_tem", int'(tem_jogada), 0);
    chk("t1_rst_erro", int'(erro_multiplo), 0);
    chk("t1_rst_estado", int'(db_estado), 0);
    reset = 1'b0;
    n_lat = 0;
    for (int i = 1; i <= 60 && n_lat == 0; i++) begin
      @(posedge clock); #1;
      if (tem_jogada) n_lat = i;
    end
    chk("t1_latency", n_lat, DEB + 3);
    chk("t1_jogada", int'(jogada), 1);
    step(5);
    botoes = 4'b0000;
    step(30);

    // 2: long hold gives a single pulse; release timing of the FSM
    p0 = pulses;
    botoes = 4'b0100;
    step(100);
    chk("t2_estado_held", int'(db_estado), 3);
    step(100);
    chk("t2_estado_held2", int'(db_estado), 3);
    botoes = 4'b0000;
    step(22);
    chk("t2_estado_solta", int'(db_estado), 4);
    step(1);
    chk("t2_estado_idle", int'(db_estado), 0);
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_jogada", int'(jogada), 4);

    // 3: bouncing press and bouncing release
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      step(3);
    end
    botoes = 4'b0010;
    step(30);
    for (int i = 0; i < 6; i++) begin
      botoes = (i % 2 == 0) ? 4'b0000 : 4'b0010;
      step(3);
    end
    botoes = 4'b0000;
    step(30);
    chk("t3_pulses", pulses - p0, 1);
    chk("t3_jogada", int'(jogada), 2);

    // 4: press while disabled is consumed; next enabled press fires
    p0 = pulses;
    habilita = 1'b0;
    botoes = 4'b1000;
    step(40);
    habilita = 1'b1;
    step(10);
    botoes = 4'b0000;
    step(30);
    chk("t4_disabled_pulses", pulses - p0, 0);
    chk("t4_jogada_kept", int'(jogada), 2);
    botoes = 4'b0001;
    step(40);
    botoes = 4'b0000;
    step(30);
    chk("t4_pulses", pulses - p0, 1);
    chk("t4_jogada", int'(jogada), 1);

    // 5: multi-button press
    p0 = pulses;
    botoes = 4'b1010;
    step(40);
    chk("t5_erro", int'(erro_multiplo), 1);
    botoes = 4'b0000;
    step(30);
`ifdef REJEITA_MULTIPLO_EN
    chk("t5_pulses", pulses - p0, 0);
    chk("t5_jogada", int'(jogada), 1);
`else
    chk("t5_pulses", pulses - p0, 1);
    chk("t5_jogada", int'(jogada), 2);
`endif

    // 6a: reset while filtering
    p0 = pulses;
    botoes = 4'b0100;
    step(6);
    chk("t6_in_filtra", int'(db_estado), 1);
    reset = 1'b1;
    #1;
    chk("t6a_estado", int'(db_estado), 0);
    chk("t6a_tem", int'(tem_jogada), 0);
    chk("t6a_erro", int'(erro_multiplo), 0);
    botoes = 4'b0000;
    step(2);
    reset = 1'b0;
    step(40);
    chk("t6a_pulses", pulses - p0, 0);

    // 6b: reset while debouncing a release
    p0 = pulses;
    botoes = 4'b0010;
    step(30);
    botoes = 4'b0000;
    step(5);
    chk("t6_in_solta", int'(db_estado), 4);
    reset = 1'b1;
    #1;
    chk("t6b_estado", int'(db_estado), 0);
    chk("t6b_jogada", int'(jogada), 0);
    step(2);
    reset = 1'b0;
    step(40);
    chk("t6b_pulses", pulses - p0, 1);

    // random activity against the reference model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: botoes = 4'b0000;
        1, 2: botoes = 4'(1 << $urandom_range(0, 3));
        default: botoes = 4'($urandom_range(0, 15));
      endcase
      habilita = ($urandom_range(0, 9) < 8);
      step($urandom_range(1, 45));
    end
    botoes = 4'b0000;
    habilita = 1'b1;
    step(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
